lfsr_rng: RTL

Parametrised Fibonacci-LFSR random number source with a valid/ready output stage, runtime reseeding, configurable decimation between samples, and all-zero lockup recovery. Successor to the fixed 12-bit generator: it feeds the GPU pixel/noise effects path, where consumers may stall, so samples are held until taken rather than overwritten.

---
 rtl/lfsr_rng.sv | 108 ++++++++++
 1 files changed

// File: rtl/lfsr_rng.sv
// Fibonacci-LFSR random source with a valid/ready sample slot, runtime reseeding,
// decimation between captured samples and all-zero lockup repair.
module lfsr_rng #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hD008,
  parameter logic [WIDTH-1:0] SEED  = 16'h0123,
  parameter int               OUT_W = 12,
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rand_ready,
  output logic             rand_valid,
  output logic [OUT_W-1:0] rand_num,
  output logic             lockup
);

  localparam logic [7:0] STEPS_G = 8'(STEPS);

  logic [WIDTH-1:0] lfsr_r;
  logic [7:0]       gap_r;

  logic             shift_s;
  logic             zero_s;
  logic             capture_s;
  logic [WIDTH-1:0] lfsr_next_s;
  logic [7:0]       gap_next_s;
  logic             valid_next_s;
  logic [OUT_W-1:0] num_next_s;
  logic             lockup_next_s;

  function automatic logic feedback(input logic [WIDTH-1:0] state);
    return ^(state & TAPS);
  endfunction

  assign shift_s   = enable & ~seed_load;
  assign zero_s    = (lfsr_r == {WIDTH{1'b0}});
  assign capture_s = shift_s & (gap_r == STEPS_G) & (~rand_valid | rand_ready);

  // Next-state decode: reseed beats shift; capture beats consume in the same cycle.
  always_comb begin
    lfsr_next_s   = lfsr_r;
    gap_next_s    = gap_r;
    valid_next_s  = rand_valid;
    num_next_s    = rand_num;
    lockup_next_s = lockup;
    if (seed_load) begin
      if (seed_in == {WIDTH{1'b0}}) begin
        lfsr_next_s = SEED;
      end else begin
        lfsr_next_s = seed_in;
      end
      gap_next_s    = STEPS_G;
      valid_next_s  = 1'b0;
      lockup_next_s = 1'b0;
    end else if (shift_s) begin
      if (zero_s) begin
        lfsr_next_s   = SEED;
        lockup_next_s = 1'b1;
      end else begin
        lfsr_next_s   = {lfsr_r[WIDTH-2:0], feedback(lfsr_r)};
      end
      if (capture_s) begin
        num_next_s   = lfsr_r[OUT_W-1:0];
        valid_next_s = 1'b1;
        gap_next_s   = 8'd1;
      end else begin
        if (gap_r < STEPS_G) begin
          gap_next_s = gap_r + 8'd1;
        end else begin
          gap_next_s = STEPS_G;
        end
        if (rand_valid && rand_ready) begin
          valid_next_s = 1'b0;
        end else begin
          valid_next_s = rand_valid;
        end
      end
    end else begin
      if (rand_valid && rand_ready) begin
        valid_next_s = 1'b0;
      end else begin
        valid_next_s = rand_valid;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r     <= SEED;
      gap_r      <= STEPS_G;
      rand_valid <= 1'b0;
      rand_num   <= {OUT_W{1'b0}};
      lockup     <= 1'b0;
    end else begin
      lfsr_r     <= lfsr_next_s;
      gap_r      <= gap_next_s;
      rand_valid <= valid_next_s;
      rand_num   <= num_next_s;
      lockup     <= lockup_next_s;
    end
  end

endmodule
